// File: rtl/box_m_sched.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// box_m_sched
//
// Round-robin scheduler sharing one box_master AXI write engine between
// NUM_REQ requesters. In IDLE it picks the first valid requester after the
// last one served, accepts its descriptor (req_ready pulse) and latches it.
// It then offers the descriptor on tran_valid/tran_ready (SEND) and holds
// the grant until box_master pulses burst_done (WAIT_DONE).
//
// Optional feature (macro BOX_SCHED_TIMEOUT_EN):
//   Adds a watchdog. If a grant lasts TIMEOUT cycles without completion,
//   ready_fall pulses, timeout_err sets (sticky until reset) and the
//   scheduler returns to IDLE, skipping the stuck requester next time.
//   With the macro undefined, ready_fall and timeout_err are tied low.
//
// Parameters:
//   NUM_REQ  number of requesters (2..16)
//   SLOT_W   descriptor width (contents are opaque here)
//   TIMEOUT  watchdog limit in cycles (watchdog build only)
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   req_valid    per-requester descriptor valid
//   req_slot     per-requester descriptor
//   req_ready    one-hot accept pulse to the granted requester (combinational)
//   tran_valid   descriptor valid to box_master
//   out_slot     latched descriptor to box_master in_slot
//   tran_ready   box_master accepts the descriptor
//   burst_done   one-cycle pulse: last write beat completed
//   ready_fall   one-cycle abort pulse to box_master
//   grant_id     index of the current or last grant
//   busy         high whenever the scheduler is not IDLE
//   timeout_err  sticky watchdog error flag
// -----------------------------------------------------------------------------
module box_m_sched #(
    parameter int  NUM_REQ = 4,
    parameter int  SLOT_W  = 32,
    parameter int  TIMEOUT = 1024,
    localparam int GW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0][SLOT_W-1:0]  req_slot,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            tran_valid,
    output logic [SLOT_W-1:0]               out_slot,
    input  logic                            tran_ready,
    input  logic                            burst_done,
    output logic                            ready_fall,
    output logic [GW-1:0]                   grant_id,
    output logic                            busy,
    output logic                            timeout_err
);

    if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT < 2) begin : g_param_check
        $error("box_m_sched: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [SLOT_W-1:0]   out_slot_reg, out_slot_next;
    logic [GW-1:0]       grant_id_reg, grant_id_next;
    logic [GW-1:0]       last_grant_reg, last_grant_next;

    logic                pick_found;
    logic [GW-1:0]       pick_idx;
    logic                grant_en;
    logic                timeout_fire;

    // -------------------------------------------------------------------------
    // Round-robin pick: scan from last_grant+1, wrapping modulo NUM_REQ, so
    // the requester served last has the lowest priority.
    // -------------------------------------------------------------------------
    always_comb begin
        int            cand;
        logic [GW-1:0] cand_idx;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = int'(last_grant_reg) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = GW'(cand);
            if (!pick_found && req_valid[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    assign grant_en = (state_reg == IDLE) && pick_found;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            out_slot_reg   <= '0;
            grant_id_reg   <= '0;
            last_grant_reg <= GW'(NUM_REQ - 1);
        end else begin
            state_reg      <= state_next;
            out_slot_reg   <= out_slot_next;
            grant_id_reg   <= grant_id_next;
            last_grant_reg <= last_grant_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        out_slot_next   = out_slot_reg;
        grant_id_next   = grant_id_reg;
        last_grant_next = last_grant_reg;
        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    state_next    = SEND;
                    out_slot_next = req_slot[pick_idx];
                    grant_id_next = pick_idx;
                end
            end
            SEND: begin
                // tran_valid is high throughout SEND, so tran_ready alone
                // completes the handshake.
                if (tran_ready) begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (burst_done) begin
                    state_next      = IDLE;
                    last_grant_next = grant_id_reg;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // Watchdog abort wins over everything; the stuck requester is treated
        // as served so arbitration moves past it.
        if (timeout_fire) begin
            state_next      = IDLE;
            last_grant_next = grant_id_reg;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        tran_valid = (state_reg == SEND);
        busy       = (state_reg != IDLE);
    end

    assign out_slot = out_slot_reg;
    assign grant_id = grant_id_reg;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req_ready
        assign req_ready[gi] = grant_en && (pick_idx == GW'(gi));
    end

`ifdef BOX_SCHED_TIMEOUT_EN
    // -------------------------------------------------------------------------
    // Watchdog. The counter is 0 in the first granted cycle, so it holds
    // TIMEOUT-1 in the TIMEOUT-th cycle. ready_fall is registered one cycle
    // early (at TIMEOUT-2) so the pulse lands in that TIMEOUT-th cycle, and
    // the FSM leaves for IDLE at the following edge.
    // -------------------------------------------------------------------------
    localparam int CW = $clog2(TIMEOUT) + 1;

    logic [CW-1:0] cnt_reg, cnt_next;
    logic          ready_fall_reg, ready_fall_next;
    logic          timeout_err_reg;
    logic          done_evt;

    assign done_evt = (state_reg == WAIT_DONE) && burst_done;

    always_comb begin
        cnt_next        = cnt_reg;
        ready_fall_next = 1'b0;
        if (grant_en) begin
            cnt_next = '0;
        end else if (state_reg != IDLE) begin
            cnt_next = cnt_reg + 1'b1;
        end
        if ((state_reg != IDLE) && !ready_fall_reg && !done_evt &&
            (cnt_reg == CW'(TIMEOUT - 2))) begin
            ready_fall_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg         <= '0;
            ready_fall_reg  <= 1'b0;
            timeout_err_reg <= 1'b0;
        end else begin
            cnt_reg         <= cnt_next;
            ready_fall_reg  <= ready_fall_next;
            timeout_err_reg <= timeout_err_reg | ready_fall_next;
        end
    end

    assign timeout_fire = ready_fall_reg;
    assign ready_fall   = ready_fall_reg;
    assign timeout_err  = timeout_err_reg;
`else
    assign timeout_fire = 1'b0;
    assign ready_fall   = 1'b0;
    assign timeout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_box_m_sched.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_box_m_sched
//
// Directed and randomized bench for box_m_sched (NUM_REQ=4, SLOT_W=32,
// TIMEOUT=16). A requester-side model tracks which requesters are pending,
// their descriptors and the last requester served, and predicts each grant
// by scanning round-robin from the last grant.
// -----------------------------------------------------------------------------
module tb_box_m_sched;

    localparam int N  = 4;
    localparam int SW = 32;
    localparam int GW = 2;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [N-1:0]            req_valid = '0;
    logic [N-1:0][SW-1:0]    req_slot = '0;
    logic                    tran_ready = 1'b0;
    logic                    burst_done = 1'b0;
    logic [N-1:0]            req_ready;
    logic                    tran_valid;
    logic [SW-1:0]           out_slot;
    logic                    ready_fall;
    logic [GW-1:0]           grant_id;
    logic                    busy;
    logic                    timeout_err;

    box_m_sched #(
        .NUM_REQ (N),
        .SLOT_W  (SW),
        .TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_slot    (req_slot),
        .req_ready   (req_ready),
        .tran_valid  (tran_valid),
        .out_slot    (out_slot),
        .tran_ready  (tran_ready),
        .burst_done  (burst_done),
        .ready_fall  (ready_fall),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_fails  = 0;

    // Requester-side model
    logic [N-1:0] pending;
    logic [SW-1:0] slots [N];
    int           last_grant;
    bit           hold_all;
    int           obs_grant;
    int           exp_rr [5] = '{0, 1, 2, 3, 0};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // First pending requester after 'last', wrapping around.
    function automatic int pick(input logic [N-1:0] p, input int last);
        for (int off = 1; off <= N; off++) begin
            int idx;
            idx = (last + off) % N;
            if (p[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_slots;
        for (int i = 0; i < N; i++) req_slot[i] = slots[i];
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_tran_valid"},  64'(tran_valid),  64'd0);
        check({tag, "_out_slot"},    64'(out_slot),    64'd0);
        check({tag, "_grant_id"},    64'(grant_id),    64'd0);
        check({tag, "_req_ready"},   64'(req_ready),   64'd0);
        check({tag, "_busy"},        64'(busy),        64'd0);
        check({tag, "_ready_fall"},  64'(ready_fall),  64'd0);
        check({tag, "_timeout_err"}, 64'(timeout_err), 64'd0);
    endtask

    // One complete burst from IDLE: grant, 'bp' cycles of backpressure in
    // SEND (optional spurious burst_done in the first of them), handshake,
    // 'wcy' idle cycles in WAIT_DONE, then burst_done. Entered and left at
    // posedge+1 of an IDLE cycle.
    task automatic burst(input int bp, input bit spurious, input int wcy);
        int            g;
        logic [SW-1:0] exp_slot;
        req_valid  = pending;
        drive_slots();
        tran_ready = (bp == 0);
        burst_done = 1'b0;
        #1;
        g = pick(pending, last_grant);
        exp_slot = slots[g];
        check("grant_req_ready", 64'(req_ready), 64'(1 << g));
        check("grant_busy", 64'(busy), 64'd0);
        tick();
        if (!hold_all) pending[g] = 1'b0;
        req_valid = pending;
        obs_grant = int'(grant_id);
        for (int b = 0; b < bp; b++) begin
            tran_ready = 1'b0;
            burst_done = spurious && (b == 0);
            #1;
            check("bp_tran_valid", 64'(tran_valid), 64'd1);
            check("bp_out_slot",   64'(out_slot),   64'(exp_slot));
            check("bp_req_ready",  64'(req_ready),  64'd0);
            tick();
            burst_done = 1'b0;
        end
        tran_ready = 1'b1;
        #1;
        check("send_tran_valid", 64'(tran_valid), 64'd1);
        check("send_out_slot",   64'(out_slot),   64'(exp_slot));
        check("send_grant_id",   64'(grant_id),   64'(g));
        tick();
        tran_ready = 1'($urandom_range(0, 1));
        for (int w = 0; w < wcy; w++) begin
            #1;
            check("wait_tran_valid", 64'(tran_valid), 64'd0);
            check("wait_busy",       64'(busy),       64'd1);
            check("wait_req_ready",  64'(req_ready),  64'd0);
            check("wait_ready_fall", 64'(ready_fall), 64'd0);
            tick();
        end
        burst_done = 1'b1;
        #1;
        check("done_tran_valid", 64'(tran_valid), 64'd0);
        check("done_busy",       64'(busy),       64'd1);
        tick();
        burst_done = 1'b0;
        tran_ready = 1'b0;
        last_grant = g;
        #1;
        check("after_done_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "tb timeout");
    end

    initial begin
        last_grant = N - 1;
        hold_all   = 1'b0;
        pending    = '0;
        obs_grant  = 0;
        for (int i = 0; i < N; i++) slots[i] = $urandom;

        // Reset state
        rst_n = 1'b0;
        #3;
        check_reset("rst");
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // burst_done in IDLE with no requests is ignored
        req_valid  = '0;
        burst_done = 1'b1;
        #1;
        check("idle_req_ready", 64'(req_ready), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        tick();
        burst_done = 1'b0;
        #1;
        check("idle_busy2", 64'(busy), 64'd0);
        check("idle_tran_valid", 64'(tran_valid), 64'd0);

        // Single request: requester 2, slot 0xA5
        pending  = 4'b0100;
        slots[2] = 32'h0000_00A5;
        burst(0, 1'b0, 0);
        check("single_grant", 64'(obs_grant), 64'd2);

        // 10 cycles of backpressure plus a spurious burst_done in SEND
        pending = 4'b0010;
        burst(10, 1'b1, 2);

        // Reset while in WAIT_DONE
        pending   = 4'b1000;
        req_valid = pending;
        drive_slots();
        tran_ready = 1'b1;
        #1;
        check("mid_req_ready", 64'(req_ready), 64'b1000);
        tick();
        pending   = '0;
        req_valid = '0;
        #1;
        check("mid_tran_valid", 64'(tran_valid), 64'd1);
        tick();
        #1;
        check("mid_wait_busy", 64'(busy), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset("midrst");
        tran_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        last_grant = N - 1;
        tick();

        // Round robin with all four held: order 0,1,2,3,0
        hold_all = 1'b1;
        pending  = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            burst($urandom_range(0, 2), 1'b0, $urandom_range(0, 2));
            check("rr_order", 64'(obs_grant), 64'(exp_rr[k]));
        end
        hold_all = 1'b0;

        // Randomized traffic
        for (int r = 0; r < 24; r++) begin
            logic [N-1:0] arrivals;
            for (int i = 0; i < N; i++) begin
                if (!pending[i]) slots[i] = $urandom;
            end
            arrivals = N'($urandom_range(0, 15));
            pending  = pending | arrivals;
            if (pending == '0) pending[$urandom_range(0, N - 1)] = 1'b1;
            burst($urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

`ifdef BOX_SCHED_TIMEOUT_EN
        // Watchdog: handshake but never complete
        begin
            int g;
            pending   = 4'b0001;
            req_valid = pending;
            drive_slots();
            tran_ready = 1'b1;
            #1;
            g = pick(pending, last_grant);
            check("to_req_ready", 64'(req_ready), 64'(1 << g));
            tick();
            pending   = '0;
            req_valid = '0;
            for (int c = 1; c <= 15; c++) begin
                #1;
                check("to_quiet_ready_fall", 64'(ready_fall), 64'd0);
                tick();
                tran_ready = 1'b0;
            end
            #1;
            check("to_ready_fall", 64'(ready_fall), 64'd1);
            check("to_err", 64'(timeout_err), 64'd1);
            check("to_busy_pulse", 64'(busy), 64'd1);
            tick();
            #1;
            check("to_idle_busy", 64'(busy), 64'd0);
            check("to_fall_clear", 64'(ready_fall), 64'd0);
            check("to_err_sticky", 64'(timeout_err), 64'd1);
            last_grant = g;
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
